pc_uart_loader: RTL and testbench

Command responder on the host side of the pinacolada UART link. Consumes received bytes from the UART receiver, decodes host commands (write word, read word, run, halt), drives a single-port word memory (instruction/data RAM), replies through the UART transmitter and controls the core's reset. Lets a host PC load and inspect the flintRV memory image over 115200-baud serial without reprogramming the FPGA.

---
 rtl/pc_uart_pkg.sv | 24 ++
 rtl/pc_uart_tx_seq.sv | 57 +++++
 rtl/pc_uart_loader.sv | 203 ++++++++++++++++++++
 tb/tb_pc_uart_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_uart_pkg.sv
// Shared constants for the pinacolada UART loader: command codes, reply bytes,
// FSM state encoding and the default inter-byte timeout.
package pc_uart_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_HALT  = 8'h48;

    localparam logic [7:0] BYTE_ACK  = 8'h06;
    localparam logic [7:0] BYTE_NAK  = 8'h15;

    localparam int TIMEOUT_CYC_DEF = 5_000_000;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_MEMW   = 3'd4;
    localparam logic [2:0] S_MEMR   = 3'd5;
    localparam logic [2:0] S_RDWAIT = 3'd6;
    localparam logic [2:0] S_RESP   = 3'd7;

endpackage

// File: rtl/pc_uart_tx_seq.sv
// Sends the low 1..4 bytes of a word, LSB first, through the tx_start/tx_done
// handshake; done is high for the cycle the final byte is seen complete.
module pc_uart_tx_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  len,
    input  logic [31:0] word,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic        done
);
    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_SEND = 2'd1;
    localparam logic [1:0] P_LOW  = 2'd2;
    localparam logic [1:0] P_HIGH = 2'd3;

    logic [1:0]  ph;
    logic [2:0]  left;
    logic [31:0] sh;

    assign done = (ph == P_HIGH) && tx_done && (left == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= P_IDLE;
            left     <= '0;
            sh       <= '0;
            tx_start <= 1'b0;
            tx_byte  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (ph)
                P_IDLE: if (start) begin
                    sh   <= word;
                    left <= len;
                    ph   <= P_SEND;
                end
                P_SEND: if (tx_done) begin
                    tx_start <= 1'b1;
                    tx_byte  <= sh[7:0];
                    sh       <= {8'h00, sh[31:8]};
                    ph       <= P_LOW;
                end
                // a byte is complete only after tx_done has been seen low, then high
                P_LOW: if (!tx_done) ph <= P_HIGH;
                P_HIGH: if (tx_done) begin
                    left <= left - 3'd1;
                    ph   <= (left == 3'd1) ? P_IDLE : P_SEND;
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pc_uart_loader.sv
// Host command responder for the pinacolada UART link (W/R/G/H commands).
// Define PC_LOADER_CHECKSUM_EN to require an XOR checksum byte after W payloads.
module pc_uart_loader
    import pc_uart_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              cpu_rst_n,
    output logic              busy
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]      state;
    logic [2:0]      cnt;
    logic [7:0]      addr_lo;
    logic [23:0]     data_sh;
    logic [31:0]     data_next;
    logic            is_write;
    logic            go_pend;
    logic [TO_W-1:0] to_cnt;
    logic            in_field;
    logic            timed_out;
    logic [31:0]     resp_word;
    logic [2:0]      resp_len;
    logic            seq_start;
    logic            seq_done;
`ifdef PC_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    // payload bytes arrive LSB first, so each new byte lands on top
    assign data_next = {rx_data, data_sh};
    assign busy      = (state != S_IDLE);
    assign in_field  = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
    assign timed_out = in_field && !rx_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_lo   <= '0;
            data_sh   <= '0;
            is_write  <= 1'b0;
            go_pend   <= 1'b0;
            to_cnt    <= '0;
            resp_word <= '0;
            resp_len  <= '0;
            seq_start <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cpu_rst_n <= 1'b0;
`ifdef PC_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            seq_start <= 1'b0;
            if (in_field) to_cnt <= rx_valid ? '0 : to_cnt + TO_W'(1);

            if (timed_out) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid) begin
                        cnt    <= '0;
                        to_cnt <= '0;
`ifdef PC_LOADER_CHECKSUM_EN
                        csum   <= '0;
`endif
                        case (rx_data)
                            CMD_WRITE: begin
                                is_write <= 1'b1;
                                state    <= S_ADDR;
                            end
                            CMD_READ: begin
                                is_write <= 1'b0;
                                state    <= S_ADDR;
                            end
                            CMD_GO: begin
                                go_pend   <= 1'b1;
                                resp_word <= {24'h0, BYTE_ACK};
                                resp_len  <= 3'd1;
                                seq_start <= 1'b1;
                                state     <= S_RESP;
                            end
                            CMD_HALT: begin
                                cpu_rst_n <= 1'b0;
                                resp_word <= {24'h0, BYTE_ACK};
                                resp_len  <= 3'd1;
                                seq_start <= 1'b1;
                                state     <= S_RESP;
                            end
                            default: begin
                                resp_word <= {24'h0, BYTE_NAK};
                                resp_len  <= 3'd1;
                                seq_start <= 1'b1;
                                state     <= S_RESP;
                            end
                        endcase
                    end
                    S_ADDR: if (rx_valid) begin
                        addr_lo <= rx_data;
                        cnt     <= cnt + 3'd1;
`ifdef PC_LOADER_CHECKSUM_EN
                        csum    <= csum ^ rx_data;
`endif
                        if (cnt == 3'd1) begin
                            // upper address bits beyond ADDR_W are dropped here
                            mem_addr <= ADDR_W'({rx_data, addr_lo});
                            cnt      <= '0;
                            if (is_write) begin
                                state <= S_DATA;
                            end else begin
                                mem_re <= 1'b1;
                                state  <= S_MEMR;
                            end
                        end
                    end
                    S_DATA: if (rx_valid) begin
                        data_sh <= data_next[31:8];
                        cnt     <= cnt + 3'd1;
`ifdef PC_LOADER_CHECKSUM_EN
                        csum    <= csum ^ rx_data;
`endif
                        if (cnt == 3'd3) begin
                            mem_wdata <= data_next;
`ifdef PC_LOADER_CHECKSUM_EN
                            state     <= S_CSUM;
`else
                            mem_we    <= 1'b1;
                            state     <= S_MEMW;
`endif
                        end
                    end
`ifdef PC_LOADER_CHECKSUM_EN
                    S_CSUM: if (rx_valid) begin
                        if (rx_data == csum) begin
                            mem_we <= 1'b1;
                            state  <= S_MEMW;
                        end else begin
                            resp_word <= {24'h0, BYTE_NAK};
                            resp_len  <= 3'd1;
                            seq_start <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
`endif
                    S_MEMW: begin
                        resp_word <= {24'h0, BYTE_ACK};
                        resp_len  <= 3'd1;
                        seq_start <= 1'b1;
                        state     <= S_RESP;
                    end
                    S_MEMR: state <= S_RDWAIT;
                    S_RDWAIT: begin
                        resp_word <= mem_rdata;
                        resp_len  <= 3'd4;
                        seq_start <= 1'b1;
                        state     <= S_RESP;
                    end
                    S_RESP: if (seq_done) begin
                        // G releases the core only once its ACK has fully left
                        if (go_pend) begin
                            cpu_rst_n <= 1'b1;
                            go_pend   <= 1'b0;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    pc_uart_tx_seq u_tx_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (seq_start),
        .len      (resp_len),
        .word     (resp_word),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .done     (seq_done)
    );

endmodule

// File: tb/tb_pc_uart_loader.sv
// Randomized self-checking bench for pc_uart_loader against a command-level model
// (expected writes, reads, TX bytes and core reset level per host command).
module tb_pc_uart_loader;
    localparam int ADDR_W = 14;
    localparam int TO     = 60;
`ifdef PC_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              cpu_rst_n;
    logic              busy;

    always #5 clk = ~clk;

    pc_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_start(tx_start), .tx_byte(tx_byte), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cpu_rst_n(cpu_rst_n), .busy(busy)
    );

    typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic [7:0]        exp_tx[$];
    logic [7:0]        tx_log[$];
    logic [31:0]       ref_mem[int];
    logic [31:0]       env_mem[0:(1<<ADDR_W)-1];
    int                checks = 0;
    int                failures = 0;
    int                tx_cnt = 0;
    logic              cpu_model = 1'b0;
    wr_t               mw;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
        end
    endtask

    // memory: write on mem_we, read data valid for exactly the cycle after mem_re
    initial begin
        logic [ADDR_W-1:0] ra;
        mem_rdata = 32'h0;
        foreach (env_mem[i]) env_mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_we) env_mem[mem_addr] = mem_wdata;
            if (rst_n && mem_re) begin
                ra = mem_addr;
                @(posedge clk); #1 mem_rdata = env_mem[ra];
                @(posedge clk); #1 mem_rdata = $urandom;
            end
        end
    end

    // transmitter: drops tx_done after accepting a byte, idle again a few cycles later
    initial begin
        int n;
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                n = $urandom_range(2, 6);
                @(posedge clk); #1 tx_done = 1'b0;
                repeat (n) @(posedge clk);
                #1 tx_done = 1'b1;
            end
        end
    end

    // compare process: every memory access and TX start against the model queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    mw = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(mw.a));
                    chk("wr_data", mem_wdata, mw.d);
                end
            end
            if (mem_re) begin
                chk("rd_expected", 32'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) chk("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
            if (tx_start) begin
                tx_log.push_back(tx_byte);
                tx_cnt++;
                chk("tx_start_when_idle", 32'(tx_done), 1);
                chk("tx_expected", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0; rx_data = $urandom;
    endtask

    task automatic wait_idle(input logic cpu_busy, input logic cpu_after, input bit inject);
        int n; bit cpu_bad; bit injd; int t0;
        n = 0; cpu_bad = 0; injd = 0; t0 = tx_cnt;
        @(negedge clk);
        chk("busy_after_cmd", 32'(busy), 1);
        while (busy && n < 800) begin
            if (cpu_rst_n !== cpu_busy) cpu_bad = 1;
            if (inject && !injd && tx_cnt != t0) begin
                rx_valid = 1'b1; rx_data = $urandom; injd = 1;
                @(negedge clk);
                rx_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            n++;
        end
        chk("cmd_completes", 32'(n < 800), 1);
        chk("cpu_rst_during_cmd", 32'(cpu_bad), 0);
        chk("cpu_rst_after_cmd", 32'(cpu_rst_n), 32'(cpu_after));
        chk("model_drained", 32'(exp_tx.size() + exp_wr.size() + exp_rd.size()), 0);
        cpu_model = cpu_after;
    endtask

    function automatic logic [31:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    function automatic logic [7:0] xor6(input logic [15:0] a, input logic [31:0] d);
        return a[7:0] ^ a[15:8] ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input bit bad, input bit inj);
        logic [7:0] cs;
        logic [ADDR_W-1:0] wa;
        wa = a[ADDR_W-1:0];
        cs = xor6(a, d);
        if (!CSUM || !bad) begin
            exp_wr.push_back('{wa, d});
            ref_mem[int'(wa)] = d;
            exp_tx.push_back(8'h06);
        end else begin
            exp_tx.push_back(8'h15);
        end
        send_byte(8'h57);
        send_byte(a[7:0]);   send_byte(a[15:8]);
        send_byte(d[7:0]);   send_byte(d[15:8]);
        send_byte(d[23:16]); send_byte(d[31:24]);
        if (CSUM) send_byte(bad ? ~cs : cs);
        wait_idle(cpu_model, cpu_model, inj);
    endtask

    task automatic do_read(input logic [15:0] a, input bit inj);
        logic [31:0] d;
        d = ref_rd(a[ADDR_W-1:0]);
        exp_rd.push_back(a[ADDR_W-1:0]);
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        send_byte(8'h52); send_byte(a[7:0]); send_byte(a[15:8]);
        wait_idle(cpu_model, cpu_model, inj);
    endtask

    task automatic do_simple(input logic [7:0] b);
        if (b == 8'h47) begin
            exp_tx.push_back(8'h06); send_byte(b); wait_idle(cpu_model, 1'b1, 0);
        end else if (b == 8'h48) begin
            exp_tx.push_back(8'h06); send_byte(b); wait_idle(1'b0, 1'b0, 0);
        end else begin
            exp_tx.push_back(8'h15); send_byte(b); wait_idle(cpu_model, cpu_model, 0);
        end
    endtask

    // command cut short: must abandon silently after TO idle cycles
    task automatic do_trunc(input logic [7:0] cmd, input int k);
        send_byte(cmd);
        for (int i = 0; i < k; i++) send_byte($urandom);
        repeat (TO - 1) @(negedge clk);
        chk("busy_before_timeout", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("idle_after_timeout", 32'(busy), 0);
        chk("cpu_rst_timeout", 32'(cpu_rst_n), 32'(cpu_model));
    endtask

    task automatic check_reset_outs();
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    task automatic async_reset();
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_reset_outs();
        exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
        cpu_model = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) a[15:14] = 2'b11;
        if ($urandom_range(0, 3) == 0) a[9] = 1'b1;
        return a;
    endfunction

    initial begin
        int t;
        logic [7:0] jb;
        repeat (3) @(posedge clk);
        #1 check_reset_outs();
        rst_n = 1'b1;

        chk("pin_csum_model", 32'(xor6(16'h0010, 32'hDEADBEEF)), 32'h32);
        do_write(16'h0010, 32'hDEADBEEF, 0, 0);
        chk("pin_w_ack", 32'(tx_log[$]), 32'h06);
        chk("pin_w_mem", env_mem[16], 32'hDEADBEEF);
        do_read(16'h0010, 0);
        chk("pin_r_bytes", {tx_log[$], tx_log[$-1], tx_log[$-2], tx_log[$-3]}, 32'hDEADBEEF);
        do_simple(8'h47);
        chk("pin_go_cpu", 32'(cpu_rst_n), 1);
        do_simple(8'h48);
        do_simple(8'h00);
        chk("pin_nak", 32'(tx_log[$]), 32'h15);
        do_write(16'h0033, 32'h12345678, 1, 0);
        chk("pin_csum_resp", 32'(tx_log[$]), CSUM ? 32'h15 : 32'h06);

        do_trunc(8'h57, 1);
        do_write(16'h0011, 32'hCAFEF00D, 0, 0);
        do_read(16'hC011, 0);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_write(rand_addr(), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
                3, 4, 5: do_read(rand_addr(), $urandom_range(0, 1) == 1);
                6: do_simple(8'h47);
                7: do_simple(8'h48);
                8: begin
                    do jb = 8'($urandom); while (jb inside {8'h57, 8'h52, 8'h47, 8'h48});
                    do_simple(jb);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) do_trunc(8'h57, $urandom_range(1, CSUM ? 6 : 5));
                    else do_trunc(8'h52, 1);
                end
            endcase
        end

        // reset while collecting write data
        do_simple(8'h47);
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        async_reset();
        do_read(16'h0020, 0);

        // reset while a read reply is on the wire
        exp_rd.push_back(14'h0010);
        for (int i = 0; i < 4; i++) exp_tx.push_back(ref_rd(14'h0010) >> (8 * i));
        t = tx_cnt;
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 200 && tx_cnt == t; i++) @(negedge clk);
        chk("resp_started", 32'(tx_cnt != t), 1);
        async_reset();
        do_write(16'h0021, 32'hA5A55A5A, 0, 0);
        do_read(16'h0021, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
